ram_burst_controller: RTL and testbench

- Main-memory slave directly downstream of the memory controller; serves all its mem_* requests against an on-chip single-port block RAM.
- Supports three transfer kinds:
  - aligned cache-line bursts, both read and write, for the instruction and data caches;
  - single-word reads;
  - open-ended streaming writes for external loaders such as the flash and UART bootloaders.
- Produces the per-word valid/request strobes and the mem_last completion pulse the controller uses to release arbitration.

---
 rtl/ram_burst_controller_pkg.sv | 26 ++
 rtl/ram_burst_controller_bram.sv | 23 ++
 rtl/ram_burst_controller.sv | 149 ++++++++++++++
 tb/tb_ram_burst_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_controller_pkg.sv
// Shared memory-bus encodings, state type and line helpers for the RAM burst controller.
// The bus constants mirror the controller's existing defines (read/write, op-size encodings).
package ram_burst_controller_pkg;

  localparam int   ADDR_BUS      = 32;
  localparam logic MEM_READ      = 1'b0;
  localparam logic MEM_WRITE     = 1'b1;
  localparam logic MEM_OP_BURST  = 1'b0;
  localparam logic MEM_OP_STREAM = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DRAIN,
    WR_BURST,
    WR_STREAM,
    WR_END,
    DONE
  } state_t;

  // Number of in-line index bits for a power-of-two burst length.
  function automatic int line_bits(input int burst_len);
    return $clog2(burst_len);
  endfunction

endpackage

// File: rtl/ram_burst_controller_bram.sv
// Single-port synchronous RAM with one-cycle read latency, written in the
// read-before-write template so synthesis maps it onto block RAM.
module bram_sp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/ram_burst_controller.sv
// Memory-controller slave serving line bursts, single-word reads and streaming
// writes against an on-chip single-port RAM, with registered bus strobes.
module ram_burst_controller
  import ram_burst_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_BUS-1:0]   mem_addr,
  input  logic                  mem_enable,
  input  logic                  mem_rw,
  input  logic                  mem_op_size,
  input  logic                  mem_finishes_op,
  input  logic [DATA_WIDTH-1:0] mem_write,
  output logic                  mem_write_req,
  output logic [DATA_WIDTH-1:0] mem_read,
  output logic                  mem_read_valid,
  output logic                  mem_last
);

  localparam int LINE_W = line_bits(BURST_LEN);

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [LINE_W-1:0]     beat;
  logic [LINE_W-1:0]     last_beat;

  logic [ADDR_WIDTH-1:0] req_index;
  logic [ADDR_WIDTH-1:0] start_index;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  unused_addr_bits;

  assign req_index        = mem_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{mem_addr[ADDR_BUS-1:ADDR_WIDTH+2], mem_addr[1:0]};
  assign start_index      = (mem_op_size == MEM_OP_BURST)
                            ? {req_index[ADDR_WIDTH-1:LINE_W], {LINE_W{1'b0}}}
                            : req_index;

  // Reads are addressed one cycle ahead (start index while still in IDLE) so the
  // registered mem_read carries word i in cycle i+2 of the transfer.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = idx;
    case (state)
      IDLE:      ram_addr = start_index;
      WR_BURST:  ram_we   = 1'b1;
      WR_STREAM: ram_we   = !mem_finishes_op;
      default:   ram_we   = 1'b0;
    endcase
  end

  bram_sp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk (clk),
    .we  (ram_we),
    .addr(ram_addr),
    .din (mem_write),
    .dout(ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      beat           <= '0;
      last_beat      <= '0;
      mem_write_req  <= 1'b0;
      mem_read_valid <= 1'b0;
      mem_last       <= 1'b0;
      mem_read       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_enable) begin
            beat <= '0;
            if (mem_rw == MEM_READ) begin
              idx       <= start_index + ADDR_WIDTH'(1);
              last_beat <= (mem_op_size == MEM_OP_STREAM) ? '0 : LINE_W'(BURST_LEN - 1);
              state     <= RD_BURST;
            end else begin
              idx           <= start_index;
              mem_write_req <= 1'b1;
              state         <= (mem_op_size == MEM_OP_BURST) ? WR_BURST : WR_STREAM;
            end
          end
        end

        RD_BURST: begin
          mem_read       <= ram_dout;
          mem_read_valid <= 1'b1;
          idx            <= idx + ADDR_WIDTH'(1);
          beat           <= beat + LINE_W'(1);
          if (beat == last_beat) begin
            mem_last <= 1'b1;
            state    <= RD_DRAIN;
          end
        end

        RD_DRAIN: begin
          mem_read_valid <= 1'b0;
          mem_last       <= 1'b0;
          state          <= DONE;
        end

        // Base is line-aligned and beat stays below BURST_LEN, so no boundary crossing.
        WR_BURST: begin
          idx  <= idx + ADDR_WIDTH'(1);
          beat <= beat + LINE_W'(1);
          if (beat == LINE_W'(BURST_LEN - 2)) begin
            mem_last <= 1'b1;
          end
          if (beat == LINE_W'(BURST_LEN - 1)) begin
            mem_write_req <= 1'b0;
            mem_last      <= 1'b0;
            state         <= DONE;
          end
        end

        WR_STREAM: begin
          if (mem_finishes_op) begin
            mem_write_req <= 1'b0;
            mem_last      <= 1'b1;
            state         <= WR_END;
          end else begin
            idx <= idx + ADDR_WIDTH'(1);
          end
        end

        WR_END: begin
          mem_last <= 1'b0;
          state    <= DONE;
        end

        // Swallows the controller's release cycle; mem_enable is not looked at here.
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_controller.sv
// Directed bench for ram_burst_controller: a transaction-level model predicts every
// cycle's strobes and read data, plus literal checks on key words and beat timing.
module tb_ram_burst_controller;
  import ram_burst_controller_pkg::*;

  localparam int BL = 8;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   mem_addr;
  logic          mem_enable;
  logic          mem_rw;
  logic          mem_op_size;
  logic          mem_finishes_op;
  logic [DW-1:0] mem_write;
  logic          mem_write_req;
  logic [DW-1:0] mem_read;
  logic          mem_read_valid;
  logic          mem_last;

  ram_burst_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_enable     (mem_enable),
    .mem_rw         (mem_rw),
    .mem_op_size    (mem_op_size),
    .mem_finishes_op(mem_finishes_op),
    .mem_write      (mem_write),
    .mem_write_req  (mem_write_req),
    .mem_read       (mem_read),
    .mem_read_valid (mem_read_valid),
    .mem_last       (mem_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          req;
    bit          valid;
    bit          last;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [0:(2**AW)-1];
  logic [31:0] cap_q[$];
  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;
  int          t_start, first_valid, last_cyc, n_valid, n_req;
  bit          chk_on = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, expv, cyc);
  endfunction

  function automatic void push(input bit req, input bit valid, input bit last, input logic [31:0] data);
    exp_t e;
    e.req = req; e.valid = valid; e.last = last; e.data = data;
    exp_q.push_back(e);
  endfunction

  function automatic void new_xfer();
    cap_q.delete();
    n_valid = 0; n_req = 0; first_valid = -1; last_cyc = -1;
    t_start = cyc;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : compare
    exp_t e;
    e.req = 1'b0; e.valid = 1'b0; e.last = 1'b0; e.data = '0;
    if (chk_on) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("write_req", 32'(mem_write_req), 32'(e.req));
      check("read_valid", 32'(mem_read_valid), 32'(e.valid));
      check("last", 32'(mem_last), 32'(e.last));
      if (e.valid) check("read_data", mem_read, e.data);
    end
    if (mem_read_valid) begin
      cap_q.push_back(mem_read);
      n_valid++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (mem_write_req) n_req++;
    if (mem_last) last_cyc = cyc;
  end

  // Read of one word (op=1) or one aligned line (op=0); caller is at the start of an IDLE cycle.
  task automatic do_read(input logic [31:0] addr, input bit op, input bit keep);
    int n = op ? 1 : BL;
    logic [AW-1:0] base = op ? addr[AW+1:2] : (addr[AW+1:2] & ~AW'(BL - 1));
    new_xfer();
    push(0, 0, 0, '0);
    push(0, 0, 0, '0);
    for (int i = 0; i < n; i++) push(0, 1, i == n - 1, model_mem[base + AW'(i)]);
    push(0, 0, 0, '0);
    mem_enable = 1'b1; mem_rw = MEM_READ; mem_op_size = op; mem_addr = addr;
    repeat (n + 2) @(posedge clk);
    #1;
    mem_enable = keep; mem_rw = MEM_WRITE; mem_op_size = MEM_OP_STREAM; mem_addr = 32'h0000_0200;
    @(posedge clk); #1;
  endtask

  // Line write; abort_at > 0 asserts rst_n in that transfer cycle.
  task automatic do_burst_write(input logic [31:0] addr, input logic [31:0] dbase, input int abort_at);
    logic [AW-1:0] base = addr[AW+1:2] & ~AW'(BL - 1);
    int stop = (abort_at > 0) ? abort_at - 1 : BL;
    new_xfer();
    push(0, 0, 0, '0);
    for (int i = 1; i <= stop; i++) push(1, 0, i == BL, '0);
    if (abort_at > 0) push(0, 0, 0, '0);
    else push(0, 0, 0, '0);
    for (int i = 0; i < stop; i++) model_mem[base + AW'(i)] = dbase + 32'(i);
    mem_enable = 1'b1; mem_rw = MEM_WRITE; mem_op_size = MEM_OP_BURST; mem_addr = addr;
    for (int c = 1; c <= BL; c++) begin
      @(posedge clk); #1;
      mem_write = dbase + 32'(c - 1);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_write_req", 32'(mem_write_req), 32'd0);
        check("rst_read_valid", 32'(mem_read_valid), 32'd0);
        check("rst_last", 32'(mem_last), 32'd0);
        check("rst_read", mem_read, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_enable = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    mem_enable = 1'b0; mem_write = 32'hDEAD_BEEF;
    @(posedge clk); #1;
  endtask

  task automatic do_stream_write(input logic [31:0] addr, input int n, input logic [31:0] dbase);
    logic [AW-1:0] start = addr[AW+1:2];
    new_xfer();
    push(0, 0, 0, '0);
    for (int i = 1; i <= n + 1; i++) push(1, 0, 0, '0);
    push(0, 0, 1, '0);
    push(0, 0, 0, '0);
    for (int i = 0; i < n; i++) model_mem[start + AW'(i)] = dbase + 32'(i);
    mem_enable = 1'b1; mem_rw = MEM_WRITE; mem_op_size = MEM_OP_STREAM; mem_addr = addr;
    for (int c = 1; c <= n + 1; c++) begin
      @(posedge clk); #1;
      mem_write = dbase + 32'(c - 1);
      mem_finishes_op = (c == n + 1);
    end
    @(posedge clk); #1;
    mem_finishes_op = 1'b0; mem_write = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_enable = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int t_first;
    rst_n = 1'b0; mem_addr = '0; mem_enable = 1'b0; mem_rw = MEM_READ;
    mem_op_size = MEM_OP_BURST; mem_finishes_op = 1'b0; mem_write = '0;
    for (int i = 0; i < 2**AW; i++) begin
      model_mem[i] = 32'hC0DE_0000 | 32'(i);
      if (i >= 'h20 && i < 'h28) model_mem[i] = 32'hA0 + 32'(i - 'h20);
      dut.u_ram.mem[i] = model_mem[i];
    end
    #1;
    check("reset_write_req", 32'(mem_write_req), 32'd0);
    check("reset_read_valid", 32'(mem_read_valid), 32'd0);
    check("reset_last", 32'(mem_last), 32'd0);
    check("reset_read", mem_read, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; chk_on = 1'b1;

    do_read(32'h0000_0094, MEM_OP_BURST, 1'b0);
    check("brd_first_valid_cycle", 32'(first_valid - t_start), 32'd2);
    check("brd_last_cycle", 32'(last_cyc - t_start), 32'd9);
    check("brd_count", 32'(n_valid), 32'd8);
    check("brd_word0", cap_q[0], 32'h0000_00A0);
    check("brd_word7", cap_q[7], 32'h0000_00A7);

    do_burst_write(32'h0000_0040, 32'h1000, 0);
    check("bwr_req_count", 32'(n_req), 32'd8);
    check("bwr_last_cycle", 32'(last_cyc - t_start), 32'd8);
    do_read(32'h0000_0040, MEM_OP_BURST, 1'b0);
    check("bwr_readback0", cap_q[0], 32'h0000_1000);
    check("bwr_readback7", cap_q[7], 32'h0000_1007);

    do_read(32'h0000_0108, MEM_OP_STREAM, 1'b0);
    check("srd_word", cap_q[0], 32'hC0DE_0042);
    check("srd_count", 32'(n_valid), 32'd1);
    check("srd_last_cycle", 32'(last_cyc - t_start), 32'd2);

    do_stream_write(32'h0003_FFF8, 5, 32'hB0);
    check("swr_req_count", 32'(n_req), 32'd6);
    check("swr_last_cycle", 32'(last_cyc - t_start), 32'd7);
    do_read(32'h0003_FFF8, MEM_OP_STREAM, 1'b0);
    check("swr_idx_fffe", cap_q[0], 32'h0000_00B0);
    do_read(32'h0003_FFFC, MEM_OP_STREAM, 1'b0);
    check("swr_idx_ffff", cap_q[0], 32'h0000_00B1);
    do_read(32'h0000_0008, MEM_OP_STREAM, 1'b0);
    check("swr_idx_0002", cap_q[0], 32'h0000_00B4);
    do_read(32'h0000_000C, MEM_OP_STREAM, 1'b0);
    check("swr_idx_0003_kept", cap_q[0], 32'hC0DE_0003);

    do_burst_write(32'h0000_0200, 32'h2000, 4);
    do_read(32'h0000_0200, MEM_OP_BURST, 1'b0);
    check("abort_word0", cap_q[0], 32'h0000_2000);
    check("abort_word2", cap_q[2], 32'h0000_2002);
    check("abort_word3_kept", cap_q[3], 32'hC0DE_0083);
    check("abort_word7_kept", cap_q[7], 32'hC0DE_0087);

    do_read(32'h0000_0094, MEM_OP_BURST, 1'b1);
    t_first = t_start;
    do_read(32'h0000_0040, MEM_OP_BURST, 1'b0);
    check("hold_restart_valid_cycle", 32'(first_valid - t_first), 32'd13);
    check("hold_second_word0", cap_q[0], 32'h0000_1000);

    repeat (3) @(posedge clk);
    #1;
    check("expect_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
